// File: rtl/multi_channel_debouncer.sv
// -----------------------------------------------------------------------------
// multi_channel_debouncer
//
// N-channel debouncer for push-buttons and slide switches. Each raw input goes
// through a two-flop synchronizer. A shared prescaler produces a sample tick,
// and on every tick each channel counts consecutive samples that disagree with
// its current debounced level. The level flips once STABLE_TICKS disagreeing
// samples have been seen in a row. A single agreeing sample restarts the count.
//
// Optional feature macro: MULTI_CHANNEL_DEBOUNCER_EDGE_PULSE_EN
//   defined   : registered one-cycle rise/fall pulses, aligned with the cycle
//               in which buttonOut first shows the new level.
//   undefined : risePulse/fallPulse are tied to zero and no pulse flops exist.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset of all state
//   enable     in   advances the sample prescaler while high
//   buttonIn   in   [CHANNELS] raw asynchronous button/switch levels
//   buttonOut  out  [CHANNELS] debounced levels (registered)
//   risePulse  out  [CHANNELS] one-cycle pulse on debounced 0->1
//   fallPulse  out  [CHANNELS] one-cycle pulse on debounced 1->0
//   sampleTick out  registered prescaler tick (debug / chaining)
// -----------------------------------------------------------------------------
module multi_channel_debouncer #(
  parameter int unsigned CHANNELS     = 5,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] buttonIn,
  output logic [CHANNELS-1:0] buttonOut,
  output logic [CHANNELS-1:0] risePulse,
  output logic [CHANNELS-1:0] fallPulse,
  output logic                sampleTick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);

  // Terminal values; counters never go past these.
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [CHANNELS-1:0] meta_r;
  logic [CHANNELS-1:0] sync_r;
  logic [CHANNELS-1:0] level_r;
  logic [DIV_W-1:0]    div_r;
  logic                tick_r;
  logic [CNT_W-1:0]    cnt_r     [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt_s [CHANNELS];
  logic [CHANNELS-1:0] differ_s;
  logic [CHANNELS-1:0] flip_s;

  // Two-flop synchronizer: the only path from the raw inputs into the design.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= {CHANNELS{RESET_LEVEL}};
      sync_r <= {CHANNELS{RESET_LEVEL}};
    end else begin
      meta_r <= buttonIn;
      sync_r <= meta_r;
    end
  end

  // Prescaler: the tick is registered, so it is high in the cycle after wrap.
  // With TICK_DIV=1 div_r stays at zero and the tick simply follows enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
    end else if (enable) begin
      if (div_r == DIV_MAX) begin
        div_r  <= {DIV_W{1'b0}};
        tick_r <= 1'b1;
      end else begin
        div_r  <= div_r + DIV_W'(1);
        tick_r <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  assign differ_s = sync_r ^ level_r;

  // Per-channel stable-sample counter next state and flip decision.
  always_comb begin
    flip_s = {CHANNELS{1'b0}};
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (tick_r) begin
        if (!differ_s[i]) begin
          // An agreeing sample throws away any partial count.
          cnt_nxt_s[i] = {CNT_W{1'b0}};
        end else if (cnt_r[i] == CNT_LAST) begin
          cnt_nxt_s[i] = {CNT_W{1'b0}};
          flip_s[i]    = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Counter and debounced level registers; they only move on tick cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r <= {CHANNELS{RESET_LEVEL}};
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      level_r <= level_r ^ flip_s;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign buttonOut  = level_r;
  assign sampleTick = tick_r;

`ifdef MULTI_CHANNEL_DEBOUNCER_EDGE_PULSE_EN
  logic [CHANNELS-1:0] rise_r;
  logic [CHANNELS-1:0] fall_r;

  // Edge pulses load on the same edge as level_r, so they line up with the
  // first cycle of the new level; the flip direction is the new sync value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_r <= {CHANNELS{1'b0}};
      fall_r <= {CHANNELS{1'b0}};
    end else begin
      rise_r <= flip_s & sync_r;
      fall_r <= flip_s & ~sync_r;
    end
  end

  assign risePulse = rise_r;
  assign fallPulse = fall_r;
`else
  assign risePulse = {CHANNELS{1'b0}};
  assign fallPulse = {CHANNELS{1'b0}};
`endif

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_debouncer
//
// Two instances: dut1 (TICK_DIV=1, STABLE_TICKS=4) for reset, clean press,
// bounce, multi-channel and mid-count reset; dut4 (TICK_DIV=4, STABLE_TICKS=4)
// for prescaler spacing and the enable freeze. Expected output events (cycle,
// level, pulses) are queued when stimulus is applied and checked by a monitor
// whenever the DUT level changes or a pulse appears.
// -----------------------------------------------------------------------------
module tb_multi_channel_debouncer;

  localparam int CH = 5;

`ifdef MULTI_CHANNEL_DEBOUNCER_EDGE_PULSE_EN
  localparam logic [CH-1:0] PMASK = 5'b11111;
`else
  localparam logic [CH-1:0] PMASK = 5'b00000;
`endif

  typedef struct {
    int            cyc;
    logic [CH-1:0] out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en1 = 1'b1;
  logic          en4 = 1'b1;
  logic [CH-1:0] bi1 = 5'b00000;
  logic [CH-1:0] bi4 = 5'b00000;
  logic [CH-1:0] bo1, rp1, fp1, bo4, rp4, fp4;
  logic          st1, st4;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t q1[$];
  ev_t q4[$];
  logic [CH-1:0] prev1 = 5'b00000;
  logic [CH-1:0] prev4 = 5'b00000;

  multi_channel_debouncer #(
    .CHANNELS(CH), .TICK_DIV(1), .STABLE_TICKS(4), .RESET_LEVEL(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .buttonIn(bi1),
    .buttonOut(bo1), .risePulse(rp1), .fallPulse(fp1), .sampleTick(st1)
  );

  multi_channel_debouncer #(
    .CHANNELS(CH), .TICK_DIV(4), .STABLE_TICKS(4), .RESET_LEVEL(1'b0)
  ) dut4 (
    .clk(clk), .reset(reset), .enable(en4), .buttonIn(bi4),
    .buttonOut(bo4), .risePulse(rp4), .fallPulse(fp4), .sampleTick(st4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input int c, input logic [CH-1:0] o,
                             input logic [CH-1:0] r, input logic [CH-1:0] f);
    ev_t e;
    e.cyc  = c;
    e.out  = o;
    e.rise = r & PMASK;
    e.fall = f & PMASK;
    return e;
  endfunction

  // Scoreboard monitor for dut1.
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      prev1 = bo1;
    end else if (bo1 !== prev1 || rp1 !== 5'b00000 || fp1 !== 5'b00000) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL dut1_unexpected_event: cycle %0d out %b rise %b fall %b expected no event",
               cyc, bo1, rp1, fp1);
      end else begin
        e = q1.pop_front();
        chk("dut1_event_cycle", cyc, e.cyc);
        chk("dut1_buttonOut", 32'(bo1), 32'(e.out));
        chk("dut1_risePulse", 32'(rp1), 32'(e.rise));
        chk("dut1_fallPulse", 32'(fp1), 32'(e.fall));
      end
      prev1 = bo1;
    end
  end

  // Scoreboard monitor for dut4.
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      prev4 = bo4;
    end else if (bo4 !== prev4 || rp4 !== 5'b00000 || fp4 !== 5'b00000) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL dut4_unexpected_event: cycle %0d out %b rise %b fall %b expected no event",
               cyc, bo4, rp4, fp4);
      end else begin
        e = q4.pop_front();
        chk("dut4_event_cycle", cyc, e.cyc);
        chk("dut4_buttonOut", 32'(bo4), 32'(e.out));
        chk("dut4_risePulse", 32'(rp4), 32'(e.rise));
        chk("dut4_fallPulse", 32'(fp4), 32'(e.fall));
      end
      prev4 = bo4;
    end
  end

  initial begin
    int  c0;
    bit  found;

    // ---- Reset state ----
    repeat (2) begin
      @(negedge clk);
      chk("rst_buttonOut1", 32'(bo1), 32'd0);
      chk("rst_rise1", 32'(rp1), 32'd0);
      chk("rst_fall1", 32'(fp1), 32'd0);
      chk("rst_tick1", 32'(st1), 32'd0);
      chk("rst_buttonOut4", 32'(bo4), 32'd0);
      chk("rst_tick4", 32'(st4), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("tick1_follows_enable", 32'(st1), 32'd1);
    repeat (3) @(negedge clk);

    // ---- Clean press / release on channel 2 ----
    bi1[2] = 1'b1;
    q1.push_back(mk(cyc + 6, 5'b00100, 5'b00100, 5'b00000));
    repeat (10) @(negedge clk);
    bi1[2] = 1'b0;
    q1.push_back(mk(cyc + 6, 5'b00000, 5'b00000, 5'b00100));
    repeat (10) @(negedge clk);

    // ---- Bounce on channel 0: high runs of 3, low runs of 1 ----
    for (int i = 0; i < 20; i++) begin
      bi1[0] = ((i % 4) != 3);
      @(negedge clk);
    end
    bi1[0] = 1'b1;
    q1.push_back(mk(cyc + 6, 5'b00001, 5'b00001, 5'b00000));
    repeat (10) @(negedge clk);
    bi1[0] = 1'b0;
    q1.push_back(mk(cyc + 6, 5'b00000, 5'b00000, 5'b00001));
    repeat (10) @(negedge clk);

    // ---- Multi-channel: all rise together, then two fall ----
    bi1 = 5'b11111;
    q1.push_back(mk(cyc + 6, 5'b11111, 5'b11111, 5'b00000));
    repeat (10) @(negedge clk);
    bi1 = 5'b10101;
    q1.push_back(mk(cyc + 6, 5'b10101, 5'b00000, 5'b01010));
    repeat (10) @(negedge clk);

    // ---- Asynchronous reset mid-count with inputs all ones ----
    bi1 = 5'b11111;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_buttonOut1", 32'(bo1), 32'd0);
    chk("async_rst_rise1", 32'(rp1), 32'd0);
    chk("async_rst_fall1", 32'(fp1), 32'd0);
    chk("async_rst_tick1", 32'(st1), 32'd0);
    chk("async_rst_tick4", 32'(st4), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("in_rst_buttonOut1", 32'(bo1), 32'd0);
      chk("in_rst_tick1", 32'(st1), 32'd0);
    end
    reset = 1'b0;
    q1.push_back(mk(cyc + 6, 5'b11111, 5'b11111, 5'b00000));
    repeat (10) @(negedge clk);

    // ---- Prescaler spacing on dut4 ----
    found = 1'b0;
    for (int t = 0; t < 8 && !found; t++) begin
      @(negedge clk);
      if (st4) found = 1'b1;
    end
    chk("align4_a", 32'(found), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("tick4_spacing", 32'(st4), 32'((i % 4) == 0));
    end

    // Baseline debounce latency, input changed on a tick cycle.
    bi4[0] = 1'b1;
    q4.push_back(mk(cyc + 17, 5'b00001, 5'b00001, 5'b00000));
    repeat (20) @(negedge clk);

    // Same change with enable low for 10 cycles mid-count: 10 cycles later.
    found = 1'b0;
    for (int t = 0; t < 8 && !found; t++) begin
      @(negedge clk);
      if (st4) found = 1'b1;
    end
    chk("align4_b", 32'(found), 32'd1);
    bi4[0] = 1'b0;
    c0 = cyc;
    q4.push_back(mk(c0 + 27, 5'b00000, 5'b00000, 5'b00001));
    repeat (7) @(negedge clk);
    en4 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("tick4_frozen", 32'(st4), 32'd0);
      chk("out4_frozen", 32'(bo4), 32'd1);
    end
    en4 = 1'b1;
    repeat (15) @(negedge clk);

    // ---- Drain: every queued event must have occurred ----
    for (int t = 0; t < 50 && (q1.size() != 0 || q4.size() != 0); t++) begin
      @(negedge clk);
    end
    chk("q1_drained", q1.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
